fetch_ctrl: RTL
===============

# fetch_ctrl

Instruction-fetch controller sitting directly upstream of the PC register. It issues reads to instruction memory at the current PC, tolerates multi-cycle memory responses, and computes and enables the next PC (PC+2 or a branch/jump redirect). It also owns the IF/ID pipeline register, holding it under decode stalls and flushing it on redirects. The `next_pc`/`pc_en` outputs drive the PC register's D/WriteReg inputs, and `pc` is that register's output.

## Interface
- No parameters; datapath is fixed at 16 bits.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `pc` input 16: current PC from the PC register; 0x0000 while `rst_n`=0.
- `next_pc` output 16: D input to the PC register.
- `pc_en` output 1: write enable to the PC register.
- `imem_rd` output 1: instruction-memory read request; held high until `imem_done`.
- `imem_addr` output 16: read address; stable while a request is outstanding.
- `imem_data` input 16: instruction, valid when `imem_done`=1.
- `imem_done` input 1: memory response; may arrive in the same cycle as `imem_rd` (hit) or later.
- `id_stall` input 1: hazard unit stall; IF/ID must hold.
- `redirect` input 1: branch/jump resolved taken; flush and refetch.
- `redirect_pc` input 16: redirect target.
- `if_instr` output 16: IF/ID instruction.
- `if_pc2` output 16: IF/ID PC+2 of that instruction.
- `if_valid` output 1: IF/ID contents valid.
- `halted` output 1: fetch stopped on HALT. Only present in behaviour under `FETCH_HALT_DETECT_EN`; tied 0 otherwise.

## Operation
- States: RUN, WAIT, HELD, DRAIN, HALT. Reset state: RUN.
- Reset values: `if_instr`=0, `if_pc2`=0, `if_valid`=0, `halted`=0, hold buffer=0, drain target=0. `imem_rd`=0 and `pc_en`=0 while `rst_n`=0.
- PC+2 is modulo 2^16, so 0xFFFE wraps to 0x0000.

RUN:
- Drive `imem_rd`=1 and `imem_addr`=`pc`.
- `redirect`: `next_pc`=`redirect_pc`, `pc_en`=1, `if_valid`←0, stay in RUN. Any same-cycle `imem_done` data is discarded.
- `imem_done` with no stall: `if_instr`←`imem_data`, `if_pc2`←`pc`+2, `if_valid`←1, `next_pc`=`pc`+2, `pc_en`=1.
- `imem_done` with `id_stall`: capture `imem_data` and `pc`+2 in the hold buffer, `pc_en`=1, go to HELD. IF/ID is unchanged.
- No `imem_done`: `pc_en`=0, go to WAIT.
- No done and no stall: IF/ID retains its contents with `if_valid`←0 (bubble). Under stall, IF/ID always holds.

WAIT:
- `imem_rd`=1 with the same address.
- On `imem_done`, behave exactly as RUN-with-done, then return to RUN.
- `redirect` while waiting: the request cannot be aborted. Latch `redirect_pc` into the drain target, `if_valid`←0, go to DRAIN.

DRAIN:
- Keep `imem_rd`=1.
- On `imem_done`: discard the data, `next_pc`=drain target, `pc_en`=1, go to RUN.
- A newer `redirect` in DRAIN overwrites the drain target.

HELD:
- `imem_rd`=0.
- When `id_stall` deasserts: hold buffer → IF/ID, `if_valid`←1, go to RUN.
- `redirect` has priority: discard the hold buffer, load the target, `if_valid`←0, go to RUN.

General rules:
- Priority: `rst_n` > `redirect` > `id_stall` > normal fetch.
- `redirect` together with `id_stall`: the flush wins and IF/ID clears.

## Timing
- A hit (`imem_done` in the request cycle) gives 1 instruction/cycle. IF/ID updates at the edge ending the request cycle, and the PC advances at the same edge.
- A miss of N extra cycles inserts N bubbles (`if_valid`=0).
- Redirect penalty is one bubble on a hit path. In DRAIN, the penalty is the remaining memory latency plus 1.
- `next_pc`, `pc_en`, `imem_rd` and `imem_addr` are combinational from state and inputs. All IF/ID outputs are registered.
- Reset is asserted asynchronously and released synchronously by the environment. Reset mid-WAIT abandons the request (`imem_rd` drops immediately), and the memory must tolerate this.

## Configuration
- `FETCH_HALT_DETECT_EN` defined: when an instruction with `[15:11]`=5'b00000 is written into IF/ID, go to HALT on the next cycle.
  - In HALT: `imem_rd`=0, `pc_en`=0, `halted`=1, and IF/ID holds the HALT instruction.
  - Exit only via `redirect` (to RUN with the target, `halted`←0) or reset.
- Undefined: opcode 00000 is not special, HALT state is unreachable, and `halted` is constant 0.

## Test plan
- Hit stream: `pc`=0x0000, `imem_done` every cycle, instructions 0x1111, 0x2222 → `if_instr`=0x1111 then 0x2222, `if_pc2`=0x0002 then 0x0004, `pc_en`=1 each cycle.
- 3-cycle miss at 0x0010 → `imem_addr`=0x0010 held 3 cycles, `if_valid`=0 for 2 cycles, then `if_instr`=data and `next_pc`=0x0012.
- `redirect`=1 to 0x0400 during WAIT → DRAIN, the returning data is discarded, `next_pc`=0x0400 on done, and `if_valid` is never 1 for the stale word.
- Done arrives with `id_stall`=1 for 2 cycles → IF/ID unchanged, `imem_rd`=0 in HELD, the buffered word appears the cycle after the stall drops, and the PC advanced exactly once.
- `pc`=0xFFFE hit → `next_pc`=0x0000, `if_pc2`=0x0000; reset asserted mid-WAIT → `imem_rd`=0 and `if_valid`=0 immediately.
- With `FETCH_HALT_DETECT_EN`: fetch 0x0000 → `halted`=1 and no further `imem_rd`; then `redirect` to 0x0020 → fetch resumes at 0x0020.

Source files
------------

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
// Instruction-fetch controller placed directly upstream of the PC register.
// It requests instruction words at the current PC and tolerates multi-cycle
// memory responses. It computes the next PC (PC+2 or a redirect target) and
// its write enable. It also owns the IF/ID pipeline register, which holds
// under decode stalls and is flushed on redirects.
//
// Optional feature macro: FETCH_HALT_DETECT_EN
//   When defined, an instruction whose opcode field [15:11] is 5'b00000 that
//   is written into IF/ID stops fetch in the HALT state. Only a redirect or a
//   reset leaves HALT. When the macro is undefined, HALT is unreachable and
//   `halted` stays 0.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   pc           current PC (output of the PC register)
//   next_pc      D input of the PC register           (combinational)
//   pc_en        write enable of the PC register      (combinational)
//   imem_rd      instruction-memory read request      (combinational)
//   imem_addr    instruction-memory read address      (combinational)
//   imem_data    instruction word, valid with imem_done
//   imem_done    memory response, may coincide with the request (hit)
//   id_stall     decode stall, IF/ID must hold
//   redirect     taken branch/jump, flush and refetch
//   redirect_pc  redirect target
//   if_instr     IF/ID instruction                    (registered)
//   if_pc2       IF/ID PC+2 of that instruction       (registered)
//   if_valid     IF/ID contents valid                 (registered)
//   halted       fetch stopped on HALT                (registered)
// -----------------------------------------------------------------------------
module fetch_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] pc,
    output logic [15:0] next_pc,
    output logic        pc_en,
    output logic        imem_rd,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        imem_done,
    input  logic        id_stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc2,
    output logic        if_valid,
    output logic        halted
);

    localparam logic [2:0] ST_RUN   = 3'd0;
    localparam logic [2:0] ST_WAIT  = 3'd1;
    localparam logic [2:0] ST_HELD  = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_HALT  = 3'd4;

`ifdef FETCH_HALT_DETECT_EN
    localparam logic HALT_DETECT = 1'b1;
`else
    localparam logic HALT_DETECT = 1'b0;
`endif

    // True when a word entering IF/ID must stop fetch.
    function automatic logic halt_hit(input logic [15:0] instr);
        return HALT_DETECT && (instr[15:11] == 5'b00000);
    endfunction

    logic [2:0]  state_r,      state_nxt_s;
    logic [15:0] if_instr_r,   if_instr_nxt_s;
    logic [15:0] if_pc2_r,     if_pc2_nxt_s;
    logic        if_valid_r,   if_valid_nxt_s;
    logic [15:0] hold_instr_r, hold_instr_nxt_s;
    logic [15:0] hold_pc2_r,   hold_pc2_nxt_s;
    logic [15:0] drain_pc_r,   drain_pc_nxt_s;
    logic        halted_r,     halted_nxt_s;
    logic [15:0] next_pc_s;
    logic        pc_en_s;
    logic        imem_rd_s;
    logic [15:0] pc_plus2_s;

    // Sequential PC increment; wraps modulo 2^16.
    assign pc_plus2_s = pc + 16'd2;

    // Next-state, PC control and IF/ID update logic.
    always_comb begin
        state_nxt_s      = state_r;
        next_pc_s        = pc;
        pc_en_s          = 1'b0;
        imem_rd_s        = 1'b0;
        if_instr_nxt_s   = if_instr_r;
        if_pc2_nxt_s     = if_pc2_r;
        if_valid_nxt_s   = if_valid_r;
        hold_instr_nxt_s = hold_instr_r;
        hold_pc2_nxt_s   = hold_pc2_r;
        drain_pc_nxt_s   = drain_pc_r;
        halted_nxt_s     = halted_r;

        case (state_r)
            ST_RUN, ST_WAIT: begin
                // PC is not written while a request is pending, so it
                // doubles as the stable request address.
                imem_rd_s = 1'b1;
                if (redirect) begin
                    // A request that completes this cycle needs no draining.
                    if ((state_r == ST_RUN) || imem_done) begin
                        next_pc_s      = redirect_pc;
                        pc_en_s        = 1'b1;
                        if_valid_nxt_s = 1'b0;
                        state_nxt_s    = ST_RUN;
                    end else begin
                        drain_pc_nxt_s = redirect_pc;
                        if_valid_nxt_s = 1'b0;
                        state_nxt_s    = ST_DRAIN;
                    end
                end else if (imem_done) begin
                    next_pc_s = pc_plus2_s;
                    pc_en_s   = 1'b1;
                    if (id_stall) begin
                        hold_instr_nxt_s = imem_data;
                        hold_pc2_nxt_s   = pc_plus2_s;
                        state_nxt_s      = ST_HELD;
                    end else begin
                        if_instr_nxt_s = imem_data;
                        if_pc2_nxt_s   = pc_plus2_s;
                        if_valid_nxt_s = 1'b1;
                        if (halt_hit(imem_data)) begin
                            state_nxt_s  = ST_HALT;
                            halted_nxt_s = 1'b1;
                        end else begin
                            state_nxt_s = ST_RUN;
                        end
                    end
                end else begin
                    state_nxt_s = ST_WAIT;
                    // A bubble goes downstream unless decode is holding IF/ID.
                    if (id_stall) begin
                        if_valid_nxt_s = if_valid_r;
                    end else begin
                        if_valid_nxt_s = 1'b0;
                    end
                end
            end

            ST_DRAIN: begin
                // The outstanding request cannot be aborted; wait it out.
                imem_rd_s      = 1'b1;
                if_valid_nxt_s = 1'b0;
                if (imem_done) begin
                    // A redirect arriving with the response is the newest target.
                    if (redirect) begin
                        next_pc_s = redirect_pc;
                    end else begin
                        next_pc_s = drain_pc_r;
                    end
                    pc_en_s     = 1'b1;
                    state_nxt_s = ST_RUN;
                end else if (redirect) begin
                    drain_pc_nxt_s = redirect_pc;
                end else begin
                    drain_pc_nxt_s = drain_pc_r;
                end
            end

            ST_HELD: begin
                // The PC was advanced on entry; only the buffered word is pending.
                if (redirect) begin
                    next_pc_s      = redirect_pc;
                    pc_en_s        = 1'b1;
                    if_valid_nxt_s = 1'b0;
                    state_nxt_s    = ST_RUN;
                end else if (!id_stall) begin
                    if_instr_nxt_s = hold_instr_r;
                    if_pc2_nxt_s   = hold_pc2_r;
                    if_valid_nxt_s = 1'b1;
                    if (halt_hit(hold_instr_r)) begin
                        state_nxt_s  = ST_HALT;
                        halted_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end else begin
                    state_nxt_s = ST_HELD;
                end
            end

            ST_HALT: begin
                if (redirect) begin
                    next_pc_s      = redirect_pc;
                    pc_en_s        = 1'b1;
                    if_valid_nxt_s = 1'b0;
                    halted_nxt_s   = 1'b0;
                    state_nxt_s    = ST_RUN;
                end else begin
                    state_nxt_s = ST_HALT;
                end
            end

            default: begin
                // Unreachable encodings recover to RUN without fetching.
                if_valid_nxt_s = 1'b0;
                halted_nxt_s   = 1'b0;
                state_nxt_s    = ST_RUN;
            end
        endcase
    end

    // State, IF/ID, hold buffer and drain target registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_RUN;
            if_instr_r   <= 16'h0000;
            if_pc2_r     <= 16'h0000;
            if_valid_r   <= 1'b0;
            hold_instr_r <= 16'h0000;
            hold_pc2_r   <= 16'h0000;
            drain_pc_r   <= 16'h0000;
            halted_r     <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            if_instr_r   <= if_instr_nxt_s;
            if_pc2_r     <= if_pc2_nxt_s;
            if_valid_r   <= if_valid_nxt_s;
            hold_instr_r <= hold_instr_nxt_s;
            hold_pc2_r   <= hold_pc2_nxt_s;
            drain_pc_r   <= drain_pc_nxt_s;
            halted_r     <= halted_nxt_s;
        end
    end

    // Request and PC-write strobes drop the moment reset asserts, abandoning
    // any outstanding request.
    assign imem_rd   = rst_n & imem_rd_s;
    assign pc_en     = rst_n & pc_en_s;
    assign imem_addr = pc;
    assign next_pc   = next_pc_s;
    assign if_instr  = if_instr_r;
    assign if_pc2    = if_pc2_r;
    assign if_valid  = if_valid_r;
    assign halted    = halted_r;

endmodule
